// File: rtl/mem_access_port.sv
// Byte-serial bus initiator: splits 1/2/4-byte little-endian loads and
// stores into single-byte memory accesses, flagging read timeouts.
module mem_access_port #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data_in,
  input  logic [7:0]  mem_data_out,
  output logic        memory_read_en,
  output logic        memory_write_en,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_acc;
  logic [31:0]   r_rdata;
  logic [1:0]    r_idx;
  logic [1:0]    r_nlast;
  logic [CW-1:0] r_cnt;
  logic          r_rsp;
  logic          r_err;
  logic          r_ill;

  logic [1:0]    w_nlast;
  logic          w_accept;
  logic          w_legal;
  logic          w_last;
  logic          w_cap;
  logic          w_tmo;
  logic [31:0]   w_acc;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_legal  = (req_size != 2'd3);
  assign w_last   = (r_idx == r_nlast);
  assign w_cap    = (r_state == S_RD) && mem_ready;
  assign w_tmo    = (r_state == S_RD) && !mem_ready
                 && (r_cnt == CW'(TIMEOUT - 1));
  assign w_acc    = r_acc
                 | ({24'd0, mem_data_out} << {r_idx, 3'b000});

  always_comb begin
    w_nlast = 2'd3;
    unique case (1'b1)
      (req_size == 2'd0): w_nlast = 2'd0;
      (req_size == 2'd1): w_nlast = 2'd1;
      default:            w_nlast = 2'd3;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal)
          w_next = req_write ? S_WR : S_RD;
      end
      S_RD: begin
        if ((w_cap && w_last) || w_tmo)
          w_next = S_IDLE;
      end
      S_WR: begin
        if (w_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_acc   <= '0;
      r_rdata <= '0;
      r_idx   <= '0;
      r_nlast <= '0;
      r_cnt   <= '0;
      r_rsp   <= 1'b0;
      r_err   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_rsp <= 1'b0;
      r_ill <= w_accept && !w_legal;
      // Illegal size answers one cycle late with no bus traffic.
      if (r_ill) begin
        r_rsp   <= 1'b1;
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
      if (w_accept && w_legal) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_nlast <= w_nlast;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_acc   <= '0;
      end
      if (r_state == S_WR) begin
        if (w_last) begin
          r_rsp   <= 1'b1;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_idx   <= r_idx + 2'd1;
          r_addr  <= r_addr + 32'd1;
          r_wdata <= {8'd0, r_wdata[31:8]};
        end
      end
      if (w_cap) begin
        if (w_last) begin
          r_rsp   <= 1'b1;
          r_err   <= 1'b0;
          r_rdata <= w_acc;
        end else begin
          r_idx  <= r_idx + 2'd1;
          r_addr <= r_addr + 32'd1;
          r_cnt  <= '0;
          r_acc  <= w_acc;
        end
      end else if (w_tmo) begin
        r_rsp   <= 1'b1;
        r_err   <= 1'b1;
        r_rdata <= r_acc;
      end else if (r_state == S_RD) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign memory_read_en  = (r_state == S_RD);
  assign memory_write_en = (r_state == S_WR);
  assign mem_addr        = r_addr;
  assign mem_data_in     = r_wdata[7:0];
  assign rsp_valid       = r_rsp;
  assign rsp_err         = r_err;
  assign rsp_rdata       = r_rdata;

endmodule

// File: tb/tb_mem_access_port.sv
// Bench for mem_access_port: byte memory with repeat-read quirk,
// directed vector table, corner sequences and random requests.
module tb_mem_access_port;

  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        memory_read_en;
  logic        memory_write_en;
  logic        mem_ready;

  mem_access_port #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .memory_read_en  (memory_read_en),
    .memory_write_en (memory_write_en),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit [7:0] dflt(input bit [31:0] a);
    return a[7:0] ^ 8'h5A ^ {6'd0, a[9:8]};
  endfunction

  // Bus-side memory: one-cycle mem_ready pulse, ignores a repeated read
  // address until a write intervenes.
  bit [7:0]  bmem [1024];
  bit        bw   [1024];
  bit [31:0] m_last;
  bit        m_lv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready    <= 1'b0;
      mem_data_out <= 8'd0;
    end else begin
      mem_ready    <= 1'b0;
      mem_data_out <= 8'($urandom);
      if (memory_write_en) begin
        bmem[mem_addr[9:0]] <= mem_data_in;
        bw[mem_addr[9:0]]   <= 1'b1;
        m_lv                <= 1'b0;
      end else if (memory_read_en
                   && !(m_lv && mem_addr == m_last)) begin
        mem_ready    <= 1'b1;
        mem_data_out <= bw[mem_addr[9:0]]
                      ? bmem[mem_addr[9:0]] : dflt(mem_addr);
        m_last       <= mem_addr;
        m_lv         <= 1'b1;
      end
    end
  end

  int we_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  int rsp_cnt = 0;

  always @(negedge clk) begin
    if (memory_write_en) we_cnt <= we_cnt + 1;
    if (memory_read_en) re_cnt <= re_cnt + 1;
    if (memory_write_en && memory_read_en) both_cnt <= both_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int n_tx = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-transaction outcome from the rules.
  bit [7:0]  rmem [bit [31:0]];
  bit [31:0] ref_la;
  bit        ref_lv = 1'b0;

  function automatic bit [7:0] rget(input bit [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function automatic void model(
    input bit w, input bit [1:0] sz, input bit [31:0] a,
    input bit [31:0] wd, output bit [31:0] rd, output bit er,
    output int lat, output int we, output int re);
    int n;
    rd = 0; er = 0; lat = 0; we = 0; re = 0;
    if (sz == 2'd3) begin
      er = 1; lat = 1;
      return;
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (w) begin
      for (int i = 0; i < n; i++)
        rmem[a + 32'(i)] = wd[8*i +: 8];
      ref_lv = 0;
      lat = n; we = n;
      return;
    end
    for (int i = 0; i < n; i++) begin
      bit [31:0] ai;
      ai = a + 32'(i);
      if (ref_lv && ai == ref_la) begin
        er = 1; lat = 2*i + TO; re = lat;
        return;
      end
      ref_la = ai; ref_lv = 1;
      rd[8*i +: 8] = rget(ai);
    end
    lat = 2*n; re = lat;
  endfunction

  task automatic do_req(
    input bit w, input bit [1:0] sz, input bit [31:0] a,
    input bit [31:0] wd, output bit [31:0] rd, output bit er,
    output int lat, output int we, output int re);
    int we0, re0, n;
    bit done;
    we0 = we_cnt; re0 = re_cnt; n = 0; done = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (sz != 2'd3) chk("accepted", req_ready, 1'b0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) done = 1;
    end
    chk("rsp_seen", done, 1'b1);
    if (done) n_tx++;
    rd = rsp_rdata; er = rsp_err;
    we = we_cnt - we0; re = re_cnt - re0;
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] rd;
    bit        er;
    int        lat;
    int        we;
    int        re;
  } vec_t;

  vec_t      tbl [$];
  bit [31:0] g_rd, m_rd;
  bit        g_er, m_er;
  int        g_lat, g_we, g_re, m_lat, m_we, m_re;

  task automatic cmp_model(input string tag);
    chk({tag, "_rdata"}, g_rd, m_rd);
    chk({tag, "_err"}, g_er, m_er);
    chk({tag, "_lat"}, g_lat, m_lat);
    chk({tag, "_we"}, g_we, m_we);
    chk({tag, "_re"}, g_re, m_re);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit        w;
    bit [1:0]  sz;
    bit [31:0] a, wd;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_data_in", mem_data_in, 8'd0);
    chk("rst_en", {memory_read_en, memory_write_en}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{1, 2, 32'h10, 32'hDEADBEEF, 0, 0, 4, 4, 0});
    tbl.push_back('{0, 2, 32'h10, 0, 32'hDEADBEEF, 0, 8, 0, 8});
    tbl.push_back('{1, 0, 32'h40, 32'h55, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 32'h12, 0, 32'hAD, 0, 2, 0, 2});
    tbl.push_back('{0, 0, 32'h12, 0, 0, 1, TO, 0, TO});
    tbl.push_back('{0, 3, 32'h20, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 3, 32'h20, 32'h12345678, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 1, 32'hFFFFFFFF, 32'hBEEF, 0, 0, 2, 2, 0});
    tbl.push_back('{0, 1, 32'hFFFFFFFF, 0, 32'hBEEF, 0, 4, 0, 4});
    tbl.push_back('{0, 1, 32'h12, 0, 32'hDEAD, 0, 4, 0, 4});

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].wd,
            m_rd, m_er, m_lat, m_we, m_re);
      do_req(tbl[i].w, tbl[i].sz, tbl[i].addr, tbl[i].wd,
             g_rd, g_er, g_lat, g_we, g_re);
      chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].rd);
      chk($sformatf("vec%0d_err", i), g_er, tbl[i].er);
      chk($sformatf("vec%0d_lat", i), g_lat, tbl[i].lat);
      chk($sformatf("vec%0d_we", i), g_we, tbl[i].we);
      chk($sformatf("vec%0d_re", i), g_re, tbl[i].re);
    end

    chk("mem10", bmem[10'h010], 8'hEF);
    chk("mem11", bmem[10'h011], 8'hBE);
    chk("mem12", bmem[10'h012], 8'hAD);
    chk("mem13", bmem[10'h013], 8'hDE);
    chk("mem40", bmem[10'h040], 8'h55);
    chk("memFFFFFFFF", bmem[10'h3FF], 8'hEF);
    chk("mem00000000", bmem[10'h000], 8'hBE);

    // Back-to-back: second request launched in the rsp_valid cycle.
    model(0, 0, 32'h12, 0, m_rd, m_er, m_lat, m_we, m_re);
    do_req(0, 0, 32'h12, 0, g_rd, g_er, g_lat, g_we, g_re);
    chk("b2b1_rdata", g_rd, 32'h000000AD);
    cmp_model("b2b1");
    chk("b2b_ready_in_rsp", req_ready, 1'b1);
    model(0, 1, 32'h11, 0, m_rd, m_er, m_lat, m_we, m_re);
    do_req(0, 1, 32'h11, 0, g_rd, g_er, g_lat, g_we, g_re);
    chk("b2b2_rdata", g_rd, 32'h0000ADBE);
    cmp_model("b2b2");

    // Reset after byte 1 of a 4-byte load has been captured.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
    req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_read_en", memory_read_en, 1'b1);
    chk("pre_rst_rsp", rsp_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_read_en", memory_read_en, 1'b0);
    chk("arst_write_en", memory_write_en, 1'b0);
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_rsp", rsp_valid, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_rst_rsp", rsp_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_la = 32'h11; ref_lv = 1'b1;
    @(posedge clk); #1;
    model(0, 2, 32'h10, 0, m_rd, m_er, m_lat, m_we, m_re);
    do_req(0, 2, 32'h10, 0, g_rd, g_er, g_lat, g_we, g_re);
    chk("post_rst_rdata", g_rd, 32'hDEADBEEF);
    cmp_model("post_rst");

    for (int k = 0; k < 40; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3
         : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0)
         ? 32'hFFFFFFFE + 32'($urandom_range(0, 3))
         : 32'h100 + 32'($urandom_range(0, 7));
      wd = $urandom;
      model(w, sz, a, wd, m_rd, m_er, m_lat, m_we, m_re);
      do_req(w, sz, a, wd, g_rd, g_er, g_lat, g_we, g_re);
      cmp_model($sformatf("rnd%0d", k));
    end

    @(posedge clk); #1;
    chk("never_both_en", both_cnt, 0);
    chk("rsp_pulses", rsp_cnt, n_tx);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
